// File: rtl/mealy_secuencia_fsm.sv
// rtl/mealy_secuencia_fsm.sv - Mealy serial pattern detector with overlap, match counter and overflow flag
// Transition table is derived from PATTERN at elaboration; y is registered, z is combinational.
module mealy_secuencia_fsm #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter int                     STATE_W     = 3,
  parameter int                     CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               w,
  input  logic               clr_cnt,
  output logic [STATE_W-1:0] y,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               overflow
);

  localparam int         NUM_STATES = 2 ** STATE_W;
  localparam logic [8:0] PAT9       = 9'(PATTERN);

  // Longest proper prefix of PATTERN that is a suffix of (first k pattern bits, then b).
  function automatic logic [STATE_W-1:0] calc_next(input int k, input logic b);
    logic [8:0] seq;
    logic [8:0] mask;
    logic [8:0] pre;
    int         best;
    seq  = ((PAT9 >> (PATTERN_LEN - k)) << 1) | 9'(b);
    best = 0;
    for (int j = 1; j < PATTERN_LEN; j++) begin
      mask = (9'd1 << j) - 9'd1;
      pre  = PAT9 >> (PATTERN_LEN - j);
      if ((j <= k + 1) && ((seq & mask) == pre)) best = j;
    end
    return STATE_W'(best);
  endfunction

  // Unreachable encodings map to S0 so an upset state recovers on the next enabled bit.
  logic [STATE_W-1:0] next_tab [NUM_STATES*2];

  for (genvar k = 0; k < NUM_STATES; k++) begin : g_tab
    for (genvar b = 0; b < 2; b++) begin : g_bit
      if (k < PATTERN_LEN) begin : g_live
        assign next_tab[k*2+b] = calc_next(k, 1'(b));
      end else begin : g_dead
        assign next_tab[k*2+b] = '0;
      end
    end
  end

  logic [STATE_W-1:0] y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               z_int;

  assign z_int = en & (y_q == STATE_W'(PATTERN_LEN - 1)) & (w == PATTERN[0]);

  always_comb begin
    y_d   = y_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (en) y_d = next_tab[{y_q, w}];
    // Clear first, so a detection in the clearing cycle leaves a count of one.
    if (clr_cnt) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
    if (z_int) begin
      if (cnt_d == '1) ovf_d = 1'b1;
      else             cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign y           = y_q;
  assign z           = z_int;
  assign match_count = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_mealy_secuencia_fsm.sv
// tb/tb_mealy_secuencia_fsm.sv - directed stimulus with a history-based reference model
// Three detectors share the inputs: 1011 / 8-bit count, 1011 / 2-bit count, 110110 / 8-bit count.
module tb_mealy_secuencia_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic w = 1'b1;
  logic clr_cnt = 1'b0;

  logic [2:0] y0, y1, y2;
  logic       z0, z1, z2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
  logic       ovf0, ovf1, ovf2;

  always #5 clk = ~clk;

  mealy_secuencia_fsm dut0 (
    .clk(clk), .rst(rst), .en(en), .w(w), .clr_cnt(clr_cnt),
    .y(y0), .z(z0), .match_count(cnt0), .overflow(ovf0)
  );

  mealy_secuencia_fsm #(.CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .w(w), .clr_cnt(clr_cnt),
    .y(y1), .z(z1), .match_count(cnt1), .overflow(ovf1)
  );

  mealy_secuencia_fsm #(.PATTERN_LEN(6), .PATTERN(6'b110110), .STATE_W(3)) dut2 (
    .clk(clk), .rst(rst), .en(en), .w(w), .clr_cnt(clr_cnt),
    .y(y2), .z(z2), .match_count(cnt2), .overflow(ovf2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int pat  [3] = '{11, 11, 54};
  int len  [3] = '{4, 4, 6};
  int maxc [3] = '{255, 3, 255};
  int hist [3] = '{0, 0, 0};
  int hn   [3] = '{0, 0, 0};
  int mcnt [3] = '{0, 0, 0};
  int movf [3] = '{0, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // State = longest k < len whose last k enabled bits equal the pattern's first k bits.
  function automatic int m_y(input int i);
    int best = 0;
    for (int k = 1; k < len[i]; k++)
      if (hn[i] >= k && (hist[i] & ((1 << k) - 1)) == (pat[i] >> (len[i] - k))) best = k;
    return best;
  endfunction

  function automatic int m_z(input int i);
    int s;
    if (!en) return 0;
    s = ((hist[i] << 1) | int'(w)) & ((1 << len[i]) - 1);
    return (hn[i] + 1 >= len[i] && s == pat[i]) ? 1 : 0;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        hist[i] = 0; hn[i] = 0; mcnt[i] = 0; movf[i] = 0;
      end else begin
        int zz;
        zz = m_z(i);
        if (clr_cnt) begin
          mcnt[i] = 0; movf[i] = 0;
        end
        if (zz == 1) begin
          if (mcnt[i] == maxc[i]) movf[i] = 1;
          else mcnt[i] = mcnt[i] + 1;
        end
        if (en) begin
          hist[i] = ((hist[i] << 1) | int'(w)) & 16'hffff;
          if (hn[i] < 64) hn[i] = hn[i] + 1;
        end
      end
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    check("y0", int'(y0), m_y(0));
    check("z0", int'(z0), m_z(0));
    check("cnt0", int'(cnt0), mcnt[0]);
    check("ovf0", int'(ovf0), movf[0]);
    check("y1", int'(y1), m_y(1));
    check("z1", int'(z1), m_z(1));
    check("cnt1", int'(cnt1), mcnt[1]);
    check("ovf1", int'(ovf1), movf[1]);
    check("y2", int'(y2), m_y(2));
    check("z2", int'(z2), m_z(2));
    check("cnt2", int'(cnt2), mcnt[2]);
    check("ovf2", int'(ovf2), movf[2]);
  end

  // Apply one input vector; check z0 mid-cycle and y0 just after the edge (-1 = skip).
  task automatic step(input bit r, input bit e, input bit wv, input bit c,
                      input int ez, input int ey);
    rst = r; en = e; w = wv; clr_cnt = c;
    @(negedge clk);
    if (ez >= 0) check("dir_z0", int'(z0), ez);
    @(posedge clk);
    #1;
    if (ey >= 0) check("dir_y0", int'(y0), ey);
  endtask

  initial begin
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    check("rst_cnt0", int'(cnt0), 0);
    check("rst_ovf0", int'(ovf0), 0);

    // overlap stream 1,0,1,1,0,1,1
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1);
    step(0, 1, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1);
    check("overlap_cnt0", int'(cnt0), 2);

    // mismatch fallback 3->2, 2->0
    step(0, 1, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 3);
    step(0, 1, 0, 0, 0, 2);
    step(0, 1, 0, 0, 0, 0);

    // enable gating at y=2
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 2);
    for (int i = 0; i < 5; i++) step(0, 0, i[0], 0, 0, 2);
    step(0, 1, 1, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1);
    check("gate_cnt1", int'(cnt1), 3);
    check("gate_ovf1", int'(ovf1), 0);

    // two more detections saturate the 2-bit counter
    for (int n = 0; n < 2; n++) begin
      step(0, 1, 0, 0, 0, 2);
      step(0, 1, 1, 0, 0, 3);
      step(0, 1, 1, 0, 1, 1);
    end
    check("sat_cnt0", int'(cnt0), 5);
    check("sat_cnt1", int'(cnt1), 3);
    check("sat_ovf1", int'(ovf1), 1);

    // clear in the same cycle as a detection
    step(0, 1, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 3);
    step(0, 1, 1, 1, 1, 1);
    check("clr_cnt1", int'(cnt1), 1);
    check("clr_ovf1", int'(ovf1), 0);
    check("clr_cnt0", int'(cnt0), 1);

    // reset at y=3 with the completing bit present
    step(0, 1, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 3);
    step(1, 1, 1, 0, 1, 0);
    check("midrst_cnt0", int'(cnt0), 0);
    check("midrst_cnt1", int'(cnt1), 0);

    // 110110110: two overlapping hits for 110110 and two for 1011
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1);
    step(0, 1, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1);
    step(0, 1, 0, 0, 0, 2);
    check("p6_cnt2", int'(cnt2), 2);
    check("p6_y2", int'(y2), 3);
    check("p6_cnt0", int'(cnt0), 2);
    check("p6_ovf0", int'(ovf0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
